dfd_trace_funnel_ctrl: RTL and testbench
========================================

# dfd_trace_funnel_ctrl

Trace funnel controller at the head of the trace network. It accepts the North and South branch outputs of the trace hop chain and buffers each branch in its own FIFO. It round-robin arbitrates both branches onto a single valid/ready trace sink and generates the backpressure, flush and enabled-source controls that are broadcast back into both branches.

## Interface
Parameters:
- NUM_CORES, 8, total trace cores; NUM_CORES_IN_PATH = NUM_CORES>>1 (localparam)
- DATA_WIDTH_IN_BYTES, 16; DATA_WIDTH = DATA_WIDTH_IN_BYTES*8
- FIFO_DEPTH, 8, entries per branch FIFO (power of 2, >= 4)
- NTRACE_BP_FREE, 5, Ntrace_Bp asserts when min free entries <= this
- DST_BP_FREE, 3, Dst_Bp asserts when min free entries <= this (< NTRACE_BP_FREE)
- FLUSH_HOLD_CYCLES, 8, cycles flush is held for network drain

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- TN_TR_North_Vld / TN_TR_South_Vld  in  NUM_CORES_IN_PATH  one-hot originating-hop valid per branch
- TN_TR_North_Src / TN_TR_South_Src  in  1  0 = ntrace, 1 = dst
- TN_TR_North_Data / TN_TR_South_Data  in  DATA_WIDTH  beat payload
- TN_TR_Ntrace_Bp, TN_TR_Dst_Bp  out  1  backpressure broadcast to both branches
- TN_TR_Ntrace_Flush, TN_TR_Dst_Flush  out  1  flush broadcast
- TN_TR_Enabled_Srcs  out  NUM_CORES  registered copy of Cfg_Enabled_Srcs
- TR_Out_Vld  out  1; TR_Out_Rdy  in  1  sink handshake
- TR_Out_Src  out  1; TR_Out_Core  out  $clog2(NUM_CORES); TR_Out_Data  out  DATA_WIDTH
- Cfg_Enabled_Srcs  in  NUM_CORES  source enable configuration
- Cfg_Flush_Req  in  1  single-cycle flush request; Cfg_Flush_Src  in  2  {dst, ntrace} select
- Flush_Done  out  1  single-cycle pulse
- Err_Ovf  out  1  sticky FIFO overflow; Err_Multihot  out  1  sticky multi-hot Vld

## Operation
- A branch beat is valid when |Vld. The FIFO entry stores {src, core, data}. core = 2*idx+0 for North and 2*idx+1 for South, where idx is the lowest set Vld bit. If more than one Vld bit is set, Err_Multihot sets and the beat is still stored.
- Push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the beat is dropped and Err_Ovf sets. Sticky errors clear only on reset.
- Output stage: a single register. It loads when empty or when TR_Out_Vld&TR_Out_Rdy. It holds Src/Core/Data stable while Vld&!Rdy.
- Arbiter: 1-bit round-robin pointer. When both FIFO heads are valid and the output stage loads, the pointer side wins and the pointer flips. A lone valid head wins without touching the pointer. Reset pointer = North.
- Backpressure: free = FIFO_DEPTH - max(count_N, count_S). Ntrace_Bp = (free <= NTRACE_BP_FREE) | flush-active. Dst_Bp = (free <= DST_BP_FREE). Both are registered. dst keeps flowing longer than ntrace.
- Flush FSM:
  - IDLE: on Cfg_Flush_Req with Cfg_Flush_Src != 0, latch the select, load counter = FLUSH_HOLD_CYCLES and go to HOLD.
  - HOLD: drive the selected Flush outputs high and decrement the counter. At 0 go to DRAIN.
  - DRAIN: Flush outputs are low. When both FIFOs are empty and the output stage is empty, go to DONE.
  - DONE: Flush_Done = 1 for one cycle, then go to IDLE.
  - Requests outside IDLE, or with select 0, are ignored.
- TN_TR_Enabled_Srcs <= Cfg_Enabled_Srcs every cycle, one-cycle delay.

## Timing
- Reset values: all outputs 0, FIFOs empty, FSM IDLE, RR pointer North.
- Latency: beat at cycle N into an empty FIFO with an idle output stage gives TR_Out_Vld at N+2. Sustained throughput is 1 beat/cycle total; each branch gets 1/2 under contention.
- Bp and Flush outputs reflect state from the previous cycle (1 register stage).
- Flush: request at cycle N gives Flush outputs high at N+1 through N+FLUSH_HOLD_CYCLES, and Flush_Done no earlier than N+FLUSH_HOLD_CYCLES+2.
- Reset asserted mid-operation: FIFO contents are discarded and every output returns to its reset value immediately (asynchronous).

## Test plan
- North beat only, Vld=4'b0100, src=1, data=0xA5.., Rdy=1 -> N+2: Out_Vld=1, Core=4, Src=1, data matches.
- Both branches stream 8 beats each, Rdy=1 -> outputs alternate N,S,N,S starting with North; 16 beats in order per branch.
- Rdy=0 with both branches pushing each cycle -> Ntrace_Bp high once free<=5 and Dst_Bp once free<=3. The 9th beat into a full FIFO sets Err_Ovf. Out_Data stays stable.
- Push and pop on a full FIFO in the same cycle -> accepted, no Err_Ovf, count remains 8.
- Cfg_Flush_Req with Src=2'b01 while 3 beats are buffered -> Ntrace_Flush high for 8 cycles, Dst_Flush low, then drain and a Flush_Done pulse. A second request during HOLD is ignored.
- Vld=4'b0011 on South -> Core=1, Err_Multihot=1. reset_n low mid-stream -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/dfd_trace_funnel_ctrl_if.sv
// Trace funnel bundle: North/South branch inputs, broadcast controls back
// into the hop chain, and the single valid/ready trace sink.
interface dfd_trace_funnel_ctrl_if #(
   parameter int unsigned NUM_CORES  = 8,
   parameter int unsigned DATA_WIDTH = 128
);
   localparam int unsigned NP = NUM_CORES >> 1;
   localparam int unsigned CW = $clog2(NUM_CORES);

   logic [NP-1:0]         TN_TR_North_Vld;
   logic                  TN_TR_North_Src;
   logic [DATA_WIDTH-1:0] TN_TR_North_Data;
   logic [NP-1:0]         TN_TR_South_Vld;
   logic                  TN_TR_South_Src;
   logic [DATA_WIDTH-1:0] TN_TR_South_Data;
   logic                  TN_TR_Ntrace_Bp;
   logic                  TN_TR_Dst_Bp;
   logic                  TN_TR_Ntrace_Flush;
   logic                  TN_TR_Dst_Flush;
   logic [NUM_CORES-1:0]  TN_TR_Enabled_Srcs;
   logic                  TR_Out_Vld;
   logic                  TR_Out_Rdy;
   logic                  TR_Out_Src;
   logic [CW-1:0]         TR_Out_Core;
   logic [DATA_WIDTH-1:0] TR_Out_Data;

   // Funnel side
   modport slave (
      input  TN_TR_North_Vld, TN_TR_North_Src, TN_TR_North_Data,
      input  TN_TR_South_Vld, TN_TR_South_Src, TN_TR_South_Data,
      input  TR_Out_Rdy,
      output TN_TR_Ntrace_Bp, TN_TR_Dst_Bp, TN_TR_Ntrace_Flush, TN_TR_Dst_Flush,
      output TN_TR_Enabled_Srcs,
      output TR_Out_Vld, TR_Out_Src, TR_Out_Core, TR_Out_Data
   );

   // Hop chain / sink side
   modport master (
      output TN_TR_North_Vld, TN_TR_North_Src, TN_TR_North_Data,
      output TN_TR_South_Vld, TN_TR_South_Src, TN_TR_South_Data,
      output TR_Out_Rdy,
      input  TN_TR_Ntrace_Bp, TN_TR_Dst_Bp, TN_TR_Ntrace_Flush, TN_TR_Dst_Flush,
      input  TN_TR_Enabled_Srcs,
      input  TR_Out_Vld, TR_Out_Src, TR_Out_Core, TR_Out_Data
   );
endinterface

// File: rtl/dfd_trace_funnel_ctrl.sv
// Trace funnel controller: per-branch FIFOs, round-robin merge onto one
// trace sink, backpressure/flush broadcast and sticky error flags.
module dfd_trace_funnel_ctrl #(
   parameter int unsigned NUM_CORES           = 8,
   parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
   parameter int unsigned FIFO_DEPTH          = 8,
   parameter int unsigned NTRACE_BP_FREE      = 5,
   parameter int unsigned DST_BP_FREE         = 3,
   parameter int unsigned FLUSH_HOLD_CYCLES   = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   dfd_trace_funnel_ctrl_if.slave tn,
   input  logic [NUM_CORES-1:0]   Cfg_Enabled_Srcs,
   input  logic                   Cfg_Flush_Req,
   input  logic [1:0]             Cfg_Flush_Src,
   output logic                   Flush_Done,
   output logic                   Err_Ovf,
   output logic                   Err_Multihot
);
   localparam int unsigned DATA_WIDTH        = DATA_WIDTH_IN_BYTES * 8;
   localparam int unsigned NUM_CORES_IN_PATH = NUM_CORES >> 1;
   localparam int unsigned CW                = $clog2(NUM_CORES);
   localparam int unsigned EW                = 1 + CW + DATA_WIDTH;
   localparam int unsigned PW                = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW              = PW + 1;
   localparam int unsigned FLW               = $clog2(FLUSH_HOLD_CYCLES + 1);

   typedef enum logic [1:0] {FL_IDLE, FL_HOLD, FL_DRAIN, FL_DONE} flush_state_e;

   function automatic int unsigned lowest_idx(input logic [NUM_CORES_IN_PATH-1:0] v);
      lowest_idx = 0;
      for (int unsigned i = NUM_CORES_IN_PATH; i > 0; i--)
         if (v[i-1]) lowest_idx = i - 1;
   endfunction

   logic [1:0]           in_vld, in_mhot, push, pop, head_vld;
   logic [1:0][EW-1:0]   in_entry, head;
   logic [1:0][CNTW-1:0] cnt_q, cnt_d;
   logic [1:0][PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]        mem_q [2][FIFO_DEPTH];
   logic                 rr_q, rr_d, sel, out_load;
   logic                 out_vld_q, out_vld_d;
   logic [EW-1:0]        out_q, out_d;
   logic [CNTW-1:0]      max_cnt, free;
   logic                 ntrace_bp_q, dst_bp_q, ovf_q, mhot_q;
   logic [NUM_CORES-1:0] enabled_q;
   flush_state_e         state_q, state_d;
   logic [FLW-1:0]       fcnt_q, fcnt_d;
   logic [1:0]           fsel_q, fsel_d, flush_q, flush_d;
   logic                 all_empty;

   // Decode each branch beat into a FIFO entry {src, core, data}
   always_comb begin
      in_vld[0]   = |tn.TN_TR_North_Vld;
      in_vld[1]   = |tn.TN_TR_South_Vld;
      in_mhot[0]  = (tn.TN_TR_North_Vld & (tn.TN_TR_North_Vld - NUM_CORES_IN_PATH'(1))) != '0;
      in_mhot[1]  = (tn.TN_TR_South_Vld & (tn.TN_TR_South_Vld - NUM_CORES_IN_PATH'(1))) != '0;
      in_entry[0] = {tn.TN_TR_North_Src, CW'(2 * lowest_idx(tn.TN_TR_North_Vld)),
                     tn.TN_TR_North_Data};
      in_entry[1] = {tn.TN_TR_South_Src, CW'(2 * lowest_idx(tn.TN_TR_South_Vld) + 1),
                     tn.TN_TR_South_Data};
   end

   // Round-robin pick between FIFO heads, output stage load, FIFO pointer/count update
   always_comb begin
      out_load  = !out_vld_q || tn.TR_Out_Rdy;
      for (int unsigned b = 0; b < 2; b++) begin
         head_vld[b] = cnt_q[b] != '0;
         head[b]     = mem_q[b][rd_ptr_q[b]];
      end
      sel       = (&head_vld) ? rr_q : head_vld[1];
      rr_d      = (out_load && (&head_vld)) ? !rr_q : rr_q;
      out_vld_d = out_vld_q;
      out_d     = out_q;
      if (out_load) begin
         out_vld_d = |head_vld;
         if (|head_vld) out_d = head[sel];
      end
      for (int unsigned b = 0; b < 2; b++) begin
         pop[b]      = out_load && head_vld[b] && (sel == 1'(b));
         push[b]     = in_vld[b] && ((cnt_q[b] < CNTW'(FIFO_DEPTH)) || pop[b]);
         cnt_d[b]    = cnt_q[b] + CNTW'(push[b]) - CNTW'(pop[b]);
         wr_ptr_d[b] = push[b] ? wr_ptr_q[b] + PW'(1) : wr_ptr_q[b];
         rd_ptr_d[b] = pop[b] ? rd_ptr_q[b] + PW'(1) : rd_ptr_q[b];
      end
   end

   // Free space of the fuller branch drives both backpressure levels
   always_comb begin
      max_cnt   = (cnt_q[0] > cnt_q[1]) ? cnt_q[0] : cnt_q[1];
      free      = CNTW'(FIFO_DEPTH) - max_cnt;
      all_empty = (cnt_q == '0) && !out_vld_q;
   end

   // Flush FSM; the hold counter leaves HOLD on the cycle it reaches zero so
   // the flush outputs stay high for exactly FLUSH_HOLD_CYCLES cycles
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      fsel_d  = fsel_q;
      unique case (state_q)
         FL_IDLE: begin
            if (Cfg_Flush_Req && (Cfg_Flush_Src != 2'b00)) begin
               fsel_d  = Cfg_Flush_Src;
               fcnt_d  = FLW'(FLUSH_HOLD_CYCLES);
               state_d = FL_HOLD;
            end
         end
         FL_HOLD: begin
            fcnt_d = fcnt_q - FLW'(1);
            if (fcnt_d == '0) state_d = FL_DRAIN;
         end
         FL_DRAIN: if (all_empty) state_d = FL_DONE;
         FL_DONE:  state_d = FL_IDLE;
         default:  state_d = FL_IDLE;
      endcase
      flush_d = (state_d == FL_HOLD) ? fsel_d : 2'b00;
   end

   // FIFO bookkeeping, output stage and arbiter pointer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
         rr_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
         rr_q      <= rr_d;
      end
   end

   // FIFO storage, written on accepted pushes only
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < 2; b++)
         if (push[b]) mem_q[b][wr_ptr_q[b]] <= in_entry[b];
   end

   // Flush state, backpressure, enabled-source copy and sticky errors
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= FL_IDLE;
         fcnt_q      <= '0;
         fsel_q      <= '0;
         flush_q     <= '0;
         ntrace_bp_q <= 1'b0;
         dst_bp_q    <= 1'b0;
         enabled_q   <= '0;
         ovf_q       <= 1'b0;
         mhot_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         fsel_q      <= fsel_d;
         flush_q     <= flush_d;
         ntrace_bp_q <= (free <= CNTW'(NTRACE_BP_FREE)) || (state_q != FL_IDLE);
         dst_bp_q    <= free <= CNTW'(DST_BP_FREE);
         enabled_q   <= Cfg_Enabled_Srcs;
         ovf_q       <= ovf_q || (|(in_vld & ~push));
         mhot_q      <= mhot_q || (|(in_vld & in_mhot));
      end
   end

   assign tn.TN_TR_Ntrace_Bp    = ntrace_bp_q;
   assign tn.TN_TR_Dst_Bp       = dst_bp_q;
   assign tn.TN_TR_Ntrace_Flush = flush_q[0];
   assign tn.TN_TR_Dst_Flush    = flush_q[1];
   assign tn.TN_TR_Enabled_Srcs = enabled_q;
   assign tn.TR_Out_Vld         = out_vld_q;
   assign tn.TR_Out_Src         = out_q[EW-1];
   assign tn.TR_Out_Core        = out_q[EW-2 -: CW];
   assign tn.TR_Out_Data        = out_q[DATA_WIDTH-1:0];
   assign Flush_Done            = (state_q == FL_DONE);
   assign Err_Ovf               = ovf_q;
   assign Err_Multihot          = mhot_q;
endmodule

// File: tb/tb_dfd_trace_funnel_ctrl.sv
// Directed bench for the trace funnel controller.
module tb_dfd_trace_funnel_ctrl;
   logic       clk;
   logic       reset_n;
   logic [7:0] Cfg_Enabled_Srcs;
   logic       Cfg_Flush_Req;
   logic [1:0] Cfg_Flush_Src;
   logic       Flush_Done, Err_Ovf, Err_Multihot;
   int         n_checks = 0;
   int         n_fail   = 0;

   dfd_trace_funnel_ctrl_if #(.NUM_CORES(8), .DATA_WIDTH(128)) tif ();

   dfd_trace_funnel_ctrl #(
      .NUM_CORES(8), .DATA_WIDTH_IN_BYTES(16), .FIFO_DEPTH(8),
      .NTRACE_BP_FREE(5), .DST_BP_FREE(3), .FLUSH_HOLD_CYCLES(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tn(tif),
      .Cfg_Enabled_Srcs(Cfg_Enabled_Srcs), .Cfg_Flush_Req(Cfg_Flush_Req),
      .Cfg_Flush_Src(Cfg_Flush_Src), .Flush_Done(Flush_Done),
      .Err_Ovf(Err_Ovf), .Err_Multihot(Err_Multihot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_n(input logic [3:0] v, input logic s, input logic [127:0] d);
      tif.TN_TR_North_Vld = v; tif.TN_TR_North_Src = s; tif.TN_TR_North_Data = d;
   endtask

   task automatic drive_s(input logic [3:0] v, input logic s, input logic [127:0] d);
      tif.TN_TR_South_Vld = v; tif.TN_TR_South_Src = s; tif.TN_TR_South_Data = d;
   endtask

   task automatic idle_in();
      drive_n(4'b0000, 1'b0, '0);
      drive_s(4'b0000, 1'b0, '0);
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      idle_in();
      tif.TR_Out_Rdy   = 1'b0;
      Cfg_Enabled_Srcs = '0;
      Cfg_Flush_Req    = 1'b0;
      Cfg_Flush_Src    = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int           nb;
      logic [127:0] last;
      logic [3:0]   v;
      int           waited;
      logic         seen;

      // Reset values and enabled-source delay
      do_reset();
      check("rst_out_vld",  tif.TR_Out_Vld, 0);
      check("rst_ntr_bp",   tif.TN_TR_Ntrace_Bp, 0);
      check("rst_dst_bp",   tif.TN_TR_Dst_Bp, 0);
      check("rst_flush",    {tif.TN_TR_Dst_Flush, tif.TN_TR_Ntrace_Flush}, 0);
      check("rst_done",     Flush_Done, 0);
      check("rst_errs",     {Err_Ovf, Err_Multihot}, 0);
      Cfg_Enabled_Srcs = 8'hA5;
      check("en_not_yet",   tif.TN_TR_Enabled_Srcs, 0);
      tick();
      check("en_delayed",   tif.TN_TR_Enabled_Srcs, 8'hA5);

      // Single North beat: Vld=0100 -> core 4, visible two edges later
      do_reset();
      tif.TR_Out_Rdy = 1'b1;
      drive_n(4'b0100, 1'b1, {16{8'hA5}});
      tick();
      idle_in();
      check("lat_n1_vld",   tif.TR_Out_Vld, 0);
      tick();
      check("lat_n2_vld",   tif.TR_Out_Vld, 1);
      check("lat_core",     tif.TR_Out_Core, 4);
      check("lat_src",      tif.TR_Out_Src, 1);
      check("lat_data",     tif.TR_Out_Data, {16{8'hA5}});
      tick();
      check("lat_consumed", tif.TR_Out_Vld, 0);

      // Both branches stream 8 beats: N,S,N,S... starting with North
      do_reset();
      tif.TR_Out_Rdy = 1'b1;
      nb = 0;
      for (int c = 0; c < 40; c++) begin
         if (c < 8) begin
            v = 4'(1 << (c % 4));
            drive_n(v, 1'b0, 128'h1000 + 128'(c));
            drive_s(v, 1'b1, 128'h2000 + 128'(c));
         end else begin
            idle_in();
         end
         tick();
         if (tif.TR_Out_Vld) begin
            if (nb < 16) begin
               check("rr_core", tif.TR_Out_Core, 128'(2 * ((nb / 2) % 4) + (nb % 2)));
               check("rr_data", tif.TR_Out_Data,
                     ((nb % 2) != 0 ? 128'h2000 : 128'h1000) + 128'(nb / 2));
            end
            nb++;
         end
      end
      check("rr_count", 128'(nb), 16);

      // Rdy=0, both pushing: Bp thresholds, overflow, stable output
      do_reset();
      for (int k = 0; k < 9; k++) begin
         drive_n(4'b0001, 1'b0, 128'h3000 + 128'(k));
         drive_s(4'b0001, 1'b1, 128'h4000 + 128'(k));
         tick();
         if (k == 1 || k == 8) begin
            check("bp_out_vld",  tif.TR_Out_Vld, 1);
            check("bp_out_data", tif.TR_Out_Data, 128'h3000);
         end
         if (k == 2) check("ntr_bp_lo", tif.TN_TR_Ntrace_Bp, 0);
         if (k == 3) check("ntr_bp_hi", tif.TN_TR_Ntrace_Bp, 1);
         if (k == 4) check("dst_bp_lo", tif.TN_TR_Dst_Bp, 0);
         if (k == 5) check("dst_bp_hi", tif.TN_TR_Dst_Bp, 1);
         if (k == 7) check("ovf_lo",    Err_Ovf, 0);
         if (k == 8) check("ovf_hi",    Err_Ovf, 1);
      end

      // Push and pop on a full South FIFO in the same cycle
      do_reset();
      for (int k = 0; k < 9; k++) begin
         drive_s(4'b0001, 1'b1, 128'h5000 + 128'(k));
         tick();
      end
      check("full_hold_data", tif.TR_Out_Data, 128'h5000);
      tif.TR_Out_Rdy = 1'b1;
      drive_s(4'b0001, 1'b1, 128'h5009);
      tick();
      idle_in();
      check("full_pp_ovf", Err_Ovf, 0);
      nb = 0;
      last = '0;
      if (tif.TR_Out_Vld) begin nb++; last = tif.TR_Out_Data; end
      for (int c = 0; c < 20; c++) begin
         tick();
         if (tif.TR_Out_Vld) begin nb++; last = tif.TR_Out_Data; end
      end
      check("full_drain_cnt",  128'(nb), 9);
      check("full_drain_last", last, 128'h5009);
      check("full_ovf_final",  Err_Ovf, 0);

      // Ntrace flush with 3 beats buffered; second request in HOLD ignored
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive_n(4'b0010, 1'b0, 128'h6000 + 128'(k));
         tick();
      end
      idle_in();
      Cfg_Flush_Req = 1'b1;
      Cfg_Flush_Src = 2'b01;
      tick();
      Cfg_Flush_Req = 1'b0;
      check("fl_ntr_h1", tif.TN_TR_Ntrace_Flush, 1);
      check("fl_dst_h1", tif.TN_TR_Dst_Flush, 0);
      for (int h = 2; h <= 10; h++) begin
         Cfg_Flush_Req = (h == 3);
         Cfg_Flush_Src = (h == 3) ? 2'b10 : 2'b01;
         tick();
         check("fl_ntr",  tif.TN_TR_Ntrace_Flush, 128'(h <= 8));
         check("fl_dst",  tif.TN_TR_Dst_Flush, 0);
         check("fl_done_early", Flush_Done, 0);
         if (h == 2) check("fl_ntr_bp", tif.TN_TR_Ntrace_Bp, 1);
      end
      Cfg_Flush_Req  = 1'b0;
      tif.TR_Out_Rdy = 1'b1;
      seen = 1'b0;
      waited = 0;
      while (!seen && waited < 20) begin
         tick();
         waited++;
         seen = Flush_Done;
      end
      check("fl_done_seen",  seen, 1);
      check("fl_done_ticks", 128'(waited), 4);
      tick();
      check("fl_done_pulse", Flush_Done, 0);

      // Multi-hot South Vld=0011 -> core 1 and sticky error
      do_reset();
      Cfg_Enabled_Srcs = 8'h3C;
      tif.TR_Out_Rdy   = 1'b1;
      drive_s(4'b0011, 1'b0, 128'h7777);
      tick();
      idle_in();
      check("mh_err", Err_Multihot, 1);
      check("mh_ovf", Err_Ovf, 0);
      tick();
      check("mh_vld",  tif.TR_Out_Vld, 1);
      check("mh_core", tif.TR_Out_Core, 1);
      check("mh_data", tif.TR_Out_Data, 128'h7777);

      // Asynchronous reset mid-stream
      drive_n(4'b1000, 1'b1, 128'h8888);
      tick();
      idle_in();
      tick();
      check("pre_rst_core", tif.TR_Out_Core, 6);
      reset_n = 1'b0;
      #1;
      check("arst_vld",  tif.TR_Out_Vld, 0);
      check("arst_data", tif.TR_Out_Data, 0);
      check("arst_core", tif.TR_Out_Core, 0);
      check("arst_mh",   Err_Multihot, 0);
      check("arst_en",   tif.TN_TR_Enabled_Srcs, 0);
      #3 reset_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
